// File: rtl/c3lib_vecsync_hs.sv
// c3lib_vecsync_hs: lossless valid/ready word transfer between unrelated clocks.
// A 2-phase req/ack toggle pair carries one DWIDTH word per round trip. The
// source word is parked in hold_q and held stable until the sink has consumed
// it and the ack toggle has returned. This makes hold_q -> rd_data safe to
// sample without per-bit synchronization.
//
// Optional feature macro: C3LIB_VECSYNC_PARITY_EN
//   defined   : hold_q carries an extra even-parity bit, checked at rd load;
//               rd_par_err is a sticky flag cleared only by rd_rst_n.
//   undefined : no parity bit, rd_par_err tied 0. Port list identical.

// Single-bit (or narrow) flop-chain synchronizer used for the toggles.
module c3lib_bitsync #(
  parameter int DWIDTH      = 1,
  parameter int RESET_VAL   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out
);

  localparam logic [DWIDTH-1:0] RST_FILL = (RESET_VAL == 0) ? '0 : '1;

  logic [SYNC_STAGES-1:0][DWIDTH-1:0] sync_q;

  // Shift the async input through SYNC_STAGES flops; the last stage is the settled copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_FILL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
  end

  assign data_out = sync_q[SYNC_STAGES-1];

endmodule

module c3lib_vecsync_hs #(
  parameter int DWIDTH      = 8,
  parameter int RESET_VAL   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_par_err
);

  localparam logic [DWIDTH-1:0] RST_FILL = (RESET_VAL == 0) ? '0 : '1;

`ifdef C3LIB_VECSYNC_PARITY_EN
  localparam int HW = DWIDTH + 1;
`else
  localparam int HW = DWIDTH;
`endif

  // Pack a data word into the hold register format (data plus optional parity on top).
  function automatic logic [HW-1:0] pack_word(input logic [DWIDTH-1:0] d);
`ifdef C3LIB_VECSYNC_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // ---------------------------------------------------------------- wr domain
  logic [HW-1:0] hold_q;
  logic          req_wr;
  logic          ack_wr_sync;
  logic          wr_fire;

  // Ready only when the last request has been acknowledged; both operands are flops.
  assign wr_ready = (req_wr == ack_wr_sync);
  assign wr_fire  = wr_valid & wr_ready;

  // Capture the word and flip the request toggle; hold_q is frozen while in flight.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      hold_q <= pack_word(RST_FILL);
      req_wr <= 1'b0;
    end else if (wr_fire) begin
      hold_q <= pack_word(wr_data);
      req_wr <= ~req_wr;
    end
  end

  // ---------------------------------------------------------------- rd domain
  logic req_rd_sync;
  logic req_seen;
  logic ack_rd;
  logic rd_load;
  logic rd_fire;

  // A new toggle is loaded only when the output slot is empty. The wr side
  // cannot issue another toggle before ack, so a toggle never arrives while full.
  assign rd_load = (req_rd_sync != req_seen) & ~rd_valid;
  assign rd_fire = rd_valid & rd_ready;

  // Output register: load from hold_q on a new request, drop valid on consume.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= RST_FILL;
      req_seen <= 1'b0;
    end else if (rd_load) begin
      rd_valid <= 1'b1;
      rd_data  <= hold_q[DWIDTH-1:0];
      req_seen <= req_rd_sync;
    end else if (rd_fire) begin
      rd_valid <= 1'b0;
    end
  end

  // Acknowledge only once the sink has taken the word, so the source stays stalled.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)    ack_rd <= 1'b0;
    else if (rd_fire) ack_rd <= req_seen;
  end

`ifdef C3LIB_VECSYNC_PARITY_EN
  logic par_err_q;

  // Even parity over data+parity must be 0; any odd result latches the sticky flag.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)                  par_err_q <= 1'b0;
    else if (rd_load && (^hold_q))  par_err_q <= 1'b1;
  end

  assign rd_par_err = par_err_q;
`else
  assign rd_par_err = 1'b0;
`endif

  // ------------------------------------------------------- toggle crossings
  c3lib_bitsync #(
    .DWIDTH      (1),
    .RESET_VAL   (0),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .data_in  (req_wr),
    .data_out (req_rd_sync)
  );

  c3lib_bitsync #(
    .DWIDTH      (1),
    .RESET_VAL   (0),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk      (wr_clk),
    .rst_n    (wr_rst_n),
    .data_in  (ack_rd),
    .data_out (ack_wr_sync)
  );

endmodule

// File: tb/tb_c3lib_vecsync_hs.sv
// Directed bench for c3lib_vecsync_hs: wr clock period 6, rd clock period 10
// (the 500/300 MHz ratio), DWIDTH=8, RESET_VAL=0, SYNC_STAGES=2.
module tb_c3lib_vecsync_hs;

  localparam int SS = 2;

  logic       wr_clk = 1'b0;
  logic       rd_clk = 1'b0;
  logic       wr_rst_n, rd_rst_n;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       rd_par_err;

  int pass  = 0;
  int total = 0;

  c3lib_vecsync_hs #(
    .DWIDTH      (8),
    .RESET_VAL   (0),
    .SYNC_STAGES (SS)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_par_err (rd_par_err)
  );

  initial forever #3 wr_clk = ~wr_clk;
  initial forever #5 rd_clk = ~rd_clk;

  task automatic test_reset();
    wr_rst_n = 0; rd_rst_n = 0;
    wr_valid = 0; wr_data = 8'h00; rd_ready = 0;
    repeat (4) @(posedge rd_clk);
    #1;
    wr_rst_n = 1; rd_rst_n = 1;
    repeat (2) @(posedge wr_clk);
    #1;
    total++; if (wr_ready !== 1'b1)   $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else pass++;
    total++; if (rd_valid !== 1'b0)   $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else pass++;
    total++; if (rd_data !== 8'h00)   $display("FAIL reset_rd_data got=%h exp=00", rd_data); else pass++;
    total++; if (rd_par_err !== 1'b0) $display("FAIL reset_par_err got=%b exp=0", rd_par_err); else pass++;
  endtask

  task automatic test_single();
    int n;
    rd_ready = 1;
    @(posedge wr_clk); #1;
    wr_data = 8'hA5; wr_valid = 1;
    @(posedge wr_clk); #1;
    wr_valid = 0;
    total++; if (wr_ready !== 1'b0) $display("FAIL single_busy wr_ready got=%b exp=0", wr_ready); else pass++;
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin @(posedge rd_clk); #1; n++; end
    total++; if (rd_valid !== 1'b1 || n > SS + 2)
      $display("FAIL single_latency rd_valid=%b after %0d rd cycles exp 1 within %0d", rd_valid, n, SS + 2);
    else pass++;
    total++; if (rd_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", rd_data); else pass++;
    @(posedge rd_clk); #1;
    total++; if (rd_valid !== 1'b0) $display("FAIL single_pulse rd_valid got=%b exp=0", rd_valid); else pass++;
    n = 0;
    while (wr_ready !== 1'b1 && n < 40) begin @(posedge wr_clk); #1; n++; end
    total++; if (wr_ready !== 1'b1) $display("FAIL single_ready_back got=%b exp=1", wr_ready); else pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] got [$];
    logic [7:0] act;
    words[0] = 8'h11; words[1] = 8'h11; words[2] = 8'h22;
    rd_ready = 1;
    fork
      begin
        int n;
        wr_valid = 1;
        for (int i = 0; i < 3; i++) begin
          wr_data = words[i];
          n = 0;
          while (wr_ready !== 1'b1 && n < 100) begin @(posedge wr_clk); #1; n++; end
          @(posedge wr_clk); #1;
          total++; if (wr_ready !== 1'b0) $display("FAIL b2b_inflight%0d wr_ready got=%b exp=0", i, wr_ready); else pass++;
        end
        wr_valid = 0;
      end
      begin
        for (int k = 0; k < 200; k++) begin
          @(posedge rd_clk); #1;
          if (rd_valid === 1'b1) got.push_back(rd_data);
        end
      end
    join
    total++; if (got.size() != 3) $display("FAIL b2b_count got=%0d exp=3", got.size()); else pass++;
    for (int i = 0; i < 3; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      total++; if (act !== words[i]) $display("FAIL b2b_word%0d got=%h exp=%h", i, act, words[i]); else pass++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit bad_hold, bad_ready;
    rd_ready = 0;
    @(posedge wr_clk); #1;
    wr_data = 8'h3C; wr_valid = 1;
    @(posedge wr_clk); #1;
    wr_valid = 0;
    wr_data = 8'hFF;
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin @(posedge rd_clk); #1; n++; end
    total++; if (rd_valid !== 1'b1) $display("FAIL bp_arrive rd_valid got=%b exp=1", rd_valid); else pass++;
    bad_hold = 0; bad_ready = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge rd_clk); #1;
      if (rd_valid !== 1'b1 || rd_data !== 8'h3C) bad_hold = 1;
      if (wr_ready !== 1'b0) bad_ready = 1;
    end
    total++; if (bad_hold)  $display("FAIL bp_hold rd_valid=%b rd_data=%h exp 1/3c", rd_valid, rd_data); else pass++;
    total++; if (bad_ready) $display("FAIL bp_wr_stall wr_ready went 1 exp 0 while stalled"); else pass++;
    rd_ready = 1;
    @(posedge rd_clk); #1;
    total++; if (rd_valid !== 1'b0) $display("FAIL bp_consume rd_valid got=%b exp=0", rd_valid); else pass++;
    n = 0;
    while (wr_ready !== 1'b1 && n < 40) begin @(posedge wr_clk); #1; n++; end
    total++; if (wr_ready !== 1'b1) $display("FAIL bp_resume wr_ready got=%b exp=1", wr_ready); else pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen;
    rd_ready = 1;
    @(posedge wr_clk); #1;
    wr_data = 8'h5A; wr_valid = 1;
    @(posedge wr_clk); #1;
    wr_valid = 0;
    wr_rst_n = 0; rd_rst_n = 0;
    total++; if (rd_valid !== 1'b0) $display("FAIL midrst_before rd_valid got=%b exp=0", rd_valid); else pass++;
    repeat (3) @(posedge rd_clk);
    #1;
    wr_rst_n = 1; rd_rst_n = 1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge rd_clk); #1;
      if (rd_valid !== 1'b0) seen = 1;
    end
    total++; if (seen)              $display("FAIL midrst_no_valid rd_valid=1 exp 0 after reset"); else pass++;
    total++; if (wr_ready !== 1'b1) $display("FAIL midrst_wr_ready got=%b exp=1", wr_ready); else pass++;
    total++; if (rd_data !== 8'h00) $display("FAIL midrst_rd_data got=%h exp=00", rd_data); else pass++;
  endtask

  task automatic test_parity();
    int n;
    rd_ready = 1;
    @(posedge wr_clk); #1;
    wr_data = 8'h01; wr_valid = 1;
    @(posedge wr_clk); #1;
    wr_valid = 0;
`ifdef C3LIB_VECSYNC_PARITY_EN
    force dut.hold_q = 9'h100;
`endif
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin @(posedge rd_clk); #1; n++; end
`ifdef C3LIB_VECSYNC_PARITY_EN
    release dut.hold_q;
    total++; if (rd_data !== 8'h00)   $display("FAIL par_data got=%h exp=00", rd_data); else pass++;
    total++; if (rd_par_err !== 1'b1) $display("FAIL par_err got=%b exp=1", rd_par_err); else pass++;
`else
    total++; if (rd_data !== 8'h01)   $display("FAIL par_data got=%h exp=01", rd_data); else pass++;
    total++; if (rd_par_err !== 1'b0) $display("FAIL par_err got=%b exp=0", rd_par_err); else pass++;
`endif
    n = 0;
    while (wr_ready !== 1'b1 && n < 40) begin @(posedge wr_clk); #1; n++; end
    wr_data = 8'h03; wr_valid = 1;
    @(posedge wr_clk); #1;
    wr_valid = 0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin @(posedge rd_clk); #1; n++; end
    total++; if (rd_data !== 8'h03) $display("FAIL par_next_data got=%h exp=03", rd_data); else pass++;
`ifdef C3LIB_VECSYNC_PARITY_EN
    total++; if (rd_par_err !== 1'b1) $display("FAIL par_sticky got=%b exp=1", rd_par_err); else pass++;
`else
    total++; if (rd_par_err !== 1'b0) $display("FAIL par_tied got=%b exp=0", rd_par_err); else pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_parity();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete, %0d/%0d so far", pass, total);
    $fatal(1, "watchdog");
  end

endmodule
